// File: rtl/llr_buf_pkg.sv
// Shared types and frame-length range checks for the LLR frame buffer controller.
package llr_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A frame must hold at least one word and fit in the RAM address space.
  localparam int MIN_FRAME_LEN = 1;

  function automatic int max_frame_len(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit frame_len_ok(input int frame_len, input int addr_width);
    return (frame_len >= MIN_FRAME_LEN) && (frame_len <= max_frame_len(addr_width));
  endfunction

endpackage

// File: rtl/llr_skid_fifo2.sv
// Two-entry output FIFO that absorbs RAM read data so the downstream stream
// can stall without losing a word already in flight.
module llr_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop_ok_d;
  logic             push_ok_d;

  // Pops on an empty FIFO and pushes into a full one (without a pop) are dropped.
  assign pop_ok_d  = pop && (count_q != 2'd0);
  assign push_ok_d = push && ((count_q != 2'd2) || pop_ok_d);

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok_d) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok_d)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_ok_d) - 2'(pop_ok_d);
    end
  end

  // Storage is not reset: the count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok_d) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/llr_frame_buffer_ctrl.sv
// LLR frame buffer sequencer: loads one frame from an input stream into a
// single-port RAM, then drains it in address order as an output stream,
// hiding the one-cycle RAM read latency behind a 2-entry FIFO.
// Optional feature macro: FRAME_REPLAY_EN adds a replay input that
// re-streams the last loaded frame without reloading it.
module llr_frame_buffer_ctrl
  import llr_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef FRAME_REPLAY_EN
  input  logic                  replay,
`endif
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // One extra counter bit so a full-address-range frame length is representable.
  localparam int               CNT_W        = ADDR_WIDTH + 1;
  localparam bit               FRAME_LEN_OK = frame_len_ok(FRAME_LEN, ADDR_WIDTH);
  localparam logic [CNT_W-1:0] FLEN_C       = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(FRAME_LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             rd_pend_q;
  logic             frame_done_q;

  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic       wr_fire_d;
  logic       rd_fire_d;
  logic       pop_d;
  logic       last_hs_d;
  logic [2:0] level_d;
  logic       replay_go_d;

`ifdef FRAME_REPLAY_EN
  logic loaded_q;

  assign replay_go_d = replay && loaded_q;

  // Remember that the RAM holds a complete frame; only a full load arms replay.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= 1'b0;
    end else if ((state_q == LOAD) && wr_fire_d && (wr_cnt_q == LAST_C)) begin
      loaded_q <= 1'b1;
    end
  end
`else
  assign replay_go_d = 1'b0;
`endif

  // Issue decisions. The FIFO slot freed by this cycle's pop counts as free,
  // which is what sustains one word per cycle with m_ready held high.
  always_comb begin
    wr_fire_d = (state_q == LOAD) && s_valid;
    pop_d     = (fifo_count != 2'd0) && m_ready;
    level_d   = 3'(fifo_count) + 3'(rd_pend_q) - 3'(pop_d);
    rd_fire_d = (state_q == DRAIN) && (rd_cnt_q < FLEN_C) && (level_d < 3'd2);
    last_hs_d = pop_d && (out_cnt_q == LAST_C);
  end

  // Main sequencer: state, address counters, read-in-flight flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_pend_q    <= rd_fire_d;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (replay_go_d) begin
            state_q   <= DRAIN;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
          end else if (start && FRAME_LEN_OK) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (wr_fire_d) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_C) begin
              state_q   <= DRAIN;
              rd_cnt_q  <= '0;
              out_cnt_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (rd_fire_d) rd_cnt_q  <= rd_cnt_q + 1'b1;
          if (pop_d)     out_cnt_q <= out_cnt_q + 1'b1;
          if (last_hs_d) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  llr_skid_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (ram_rdata),
    .pop       (pop_d),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign s_ready    = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign m_valid    = (fifo_count != 2'd0);
  assign m_data     = fifo_head;
  assign m_last     = m_valid && (out_cnt_q == LAST_C);
  assign frame_done = frame_done_q;

  // RAM port: a write wins in LOAD, a read in DRAIN; otherwise deselect so
  // the RAM output keeps its last value.
  assign ram_cs    = wr_fire_d || rd_fire_d;
  assign ram_we    = wr_fire_d;
  assign ram_addr  = wr_fire_d ? wr_cnt_q[ADDR_WIDTH-1:0]
                   : (rd_fire_d ? rd_cnt_q[ADDR_WIDTH-1:0] : '0);
  assign ram_wdata = s_data;

endmodule

// File: tb/tb_llr_frame_buffer_ctrl.sv
// Bench for llr_frame_buffer_ctrl: three instances (FRAME_LEN 16, 256, 1)
// share stimulus; each has its own RAM model. Replay tests need FRAME_REPLAY_EN.
module tb_llr_frame_buffer_ctrl;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, s_valid, m_ready;
  logic [7:0] s_data;
`ifdef FRAME_REPLAY_EN
  logic       replay;
`endif

  logic [NDUT-1:0] s_ready_w, m_valid_w, m_last_w, busy_w, frame_done_w, ram_cs_w, ram_we_w;
  logic [7:0]      m_data_w    [NDUT];
  logic [7:0]      ram_addr_w  [NDUT];
  logic [7:0]      ram_wdata_w [NDUT];

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int FL = (gi == 0) ? 16 : ((gi == 1) ? 256 : 1);
      logic [7:0] mem [256];
      logic [7:0] rdata;

      llr_frame_buffer_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .FRAME_LEN(FL)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef FRAME_REPLAY_EN
        .replay     (replay),
`endif
        .s_valid    (s_valid),
        .s_ready    (s_ready_w[gi]),
        .s_data     (s_data),
        .m_valid    (m_valid_w[gi]),
        .m_ready    (m_ready),
        .m_data     (m_data_w[gi]),
        .m_last     (m_last_w[gi]),
        .busy       (busy_w[gi]),
        .frame_done (frame_done_w[gi]),
        .ram_cs     (ram_cs_w[gi]),
        .ram_we     (ram_we_w[gi]),
        .ram_addr   (ram_addr_w[gi]),
        .ram_wdata  (ram_wdata_w[gi]),
        .ram_rdata  (rdata)
      );

      always @(posedge clk) begin
        if (ram_cs_w[gi]) begin
          if (ram_we_w[gi]) mem[ram_addr_w[gi]] <= ram_wdata_w[gi];
          else              rdata <= mem[ram_addr_w[gi]];
        end
      end
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor of the selected instance, sampled on the falling edge.
  int         mon = 0;
  int         cyc = 0;
  int         rd_n, fd_n, stall_err, last_wr_cyc;
  int         od_q[$], ol_q[$], hs_t[$], wr_addrs[$];
  bit         stall_prev;
  logic [7:0] stall_data;

  task automatic clear_mon();
    rd_n = 0; fd_n = 0; stall_err = 0; last_wr_cyc = 0; stall_prev = 0;
    od_q.delete(); ol_q.delete(); hs_t.delete(); wr_addrs.delete();
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (ram_cs_w[mon] && ram_we_w[mon]) begin
          wr_addrs.push_back(int'(ram_addr_w[mon]));
          last_wr_cyc = cyc;
        end
        if (ram_cs_w[mon] && !ram_we_w[mon]) rd_n++;
        if (frame_done_w[mon]) fd_n++;
        if (stall_prev && (!m_valid_w[mon] || (m_data_w[mon] != stall_data))) stall_err++;
        if (m_valid_w[mon] && m_ready) begin
          od_q.push_back(int'(m_data_w[mon]));
          ol_q.push_back(int'(m_last_w[mon]));
          hs_t.push_back(cyc);
        end
        stall_prev = m_valid_w[mon] && !m_ready;
        stall_data = m_data_w[mon];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0;
`ifdef FRAME_REPLAY_EN
    replay = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
  endtask

  // Pulse start, then stream n words base+i; returns in the first DRAIN cycle.
  task automatic load_frame(input int d, input int n, input int base, input bit gaps);
    int i = 0;
    int guard = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (i < n && guard < 4 * n + 20) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = 8'(base + i);
      @(negedge clk);
      if (s_valid && s_ready_w[d]) i++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    chk("load_words_accepted", i, n);
  endtask

  task automatic drain(input bit random_ready, input int target);
    int guard = 0;
    while (fd_n < target && guard < 2000) begin
      m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    m_ready = 1'b1;
    chk("frame_done_count", fd_n, target);
  endtask

  task automatic check_frame(input int n, input int base);
    int lasts = 0;
    chk("out_count", od_q.size(), n);
    for (int i = 0; i < n && i < od_q.size(); i++) begin
      chk($sformatf("out_data[%0d]", i), od_q[i], (base + i) % 256);
      lasts += ol_q[i];
    end
    chk("m_last_count", lasts, 1);
    if (od_q.size() >= n && n > 0) chk("m_last_position", ol_q[n-1], 1);
  endtask

  task automatic check_spread(input int n);
    if (hs_t.size() >= n) chk("output_gapless_span", hs_t[n-1] - hs_t[0], n - 1);
    else                  chk("handshake_count", hs_t.size(), n);
  endtask

  typedef struct {
    bit         st;
    bit         sv;
    bit         mr;
    logic [7:0] sd;
    logic [6:0] fl;   // {s_ready, m_valid, m_last, busy, frame_done, ram_cs, ram_we}
    logic [7:0] md;
  } vec_t;

  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
`ifdef FRAME_REPLAY_EN
    replay = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_flags[%0d]", d),
          int'({s_ready_w[d], m_valid_w[d], m_last_w[d], busy_w[d],
                frame_done_w[d], ram_cs_w[d], ram_we_w[d]}), 0);
      chk($sformatf("reset_addr[%0d]", d), int'(ram_addr_w[d]), 0);
    end
    @(posedge clk); #1; rst = 1'b0;

    // Cycle-exact walk through a FRAME_LEN=1 frame (instance 2).
    vt[0] = '{0, 0, 1, 8'h00, 7'b0000000, 8'h00};
    vt[1] = '{1, 0, 1, 8'h00, 7'b0000000, 8'h00};
    vt[2] = '{0, 1, 1, 8'hA5, 7'b1001011, 8'h00};
    vt[3] = '{0, 1, 1, 8'h5A, 7'b0001010, 8'h00};
    vt[4] = '{0, 0, 1, 8'h00, 7'b0001000, 8'h00};
    vt[5] = '{0, 0, 0, 8'h00, 7'b0111000, 8'hA5};
    vt[6] = '{0, 0, 0, 8'h00, 7'b0111000, 8'hA5};
    vt[7] = '{0, 0, 1, 8'h00, 7'b0111000, 8'hA5};
    vt[8] = '{0, 0, 1, 8'h00, 7'b0000100, 8'h00};
    vt[9] = '{0, 0, 1, 8'h00, 7'b0000000, 8'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = vt[i].st; s_valid = vt[i].sv; m_ready = vt[i].mr; s_data = vt[i].sd;
      @(negedge clk);
      chk($sformatf("len1_flags[%0d]", i),
          int'({s_ready_w[2], m_valid_w[2], m_last_w[2], busy_w[2],
                frame_done_w[2], ram_cs_w[2], ram_we_w[2]}), int'(vt[i].fl));
      if (vt[i].fl[5]) chk($sformatf("len1_data[%0d]", i), int'(m_data_w[2]), int'(vt[i].md));
    end
    start = 1'b0; s_valid = 1'b0;

    // Steady load and full-rate drain, FRAME_LEN=16.
    mon = 0;
    do_reset();
    m_ready = 1'b1;
    load_frame(0, 16, 0, 1'b0);
    drain(1'b0, 1);
    chk("write_count_16", wr_addrs.size(), 16);
    for (int i = 0; i < 16 && i < wr_addrs.size(); i++) chk($sformatf("write_addr[%0d]", i), wr_addrs[i], i);
    check_frame(16, 0);
    if (hs_t.size() > 0) chk("first_valid_latency", hs_t[0] - last_wr_cyc, 3);
    else                 chk("first_valid_seen", 0, 1);
    check_spread(16);

    // Random input gaps and output backpressure.
    do_reset();
    load_frame(0, 16, 32, 1'b1);
    drain(1'b1, 1);
    check_frame(16, 32);
    chk("stall_stability", stall_err, 0);

    // Held-off drain: at most two reads, first word held, then gapless.
    do_reset();
    m_ready = 1'b0;
    load_frame(0, 16, 64, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("reads_while_stalled", rd_n, 2);
    chk("stalled_m_valid", int'(m_valid_w[0]), 1);
    chk("stalled_m_data", int'(m_data_w[0]), 64);
    @(posedge clk); #1;
    drain(1'b0, 1);
    check_frame(16, 64);
    check_spread(16);
    chk("stall_stability_hold", stall_err, 0);

    // Reset at word 5 of the drain, then a clean reload.
    do_reset();
    m_ready = 1'b1;
    load_frame(0, 16, 0, 1'b0);
    for (int g = 0; g < 40 && od_q.size() < 5; g++) begin @(posedge clk); #1; end
    chk("words_before_reset", od_q.size(), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", int'(busy_w[0]), 0);
    chk("post_reset_m_valid", int'(m_valid_w[0]), 0);
    chk("post_reset_ram_cs", int'(ram_cs_w[0]), 0);
    clear_mon();
    load_frame(0, 16, 128, 1'b0);
    drain(1'b0, 1);
    check_frame(16, 128);

    // Full address range, FRAME_LEN=256.
    mon = 1;
    do_reset();
    load_frame(1, 256, 0, 1'b0);
    drain(1'b0, 1);
    chk("write_count_256", wr_addrs.size(), 256);
    for (int i = 0; i < 256 && i < wr_addrs.size(); i++) chk($sformatf("write_addr256[%0d]", i), wr_addrs[i], i);
    check_frame(256, 0);

`ifdef FRAME_REPLAY_EN
    // Replay: ignored before any load; twice re-streams the stored frame.
    mon = 0;
    do_reset();
    @(posedge clk); #1; replay = 1'b1;
    @(posedge clk); #1; replay = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("replay_before_load_busy", int'(busy_w[0]), 0);
    load_frame(0, 16, 16, 1'b0);
    drain(1'b0, 1);
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      @(posedge clk); #1; replay = 1'b1; start = (r == 1);
      @(posedge clk); #1; replay = 1'b0; start = 1'b0;
      drain(1'b0, 1);
      check_frame(16, 16);
      chk($sformatf("replay_writes[%0d]", r), wr_addrs.size(), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
